// File: rtl/ipg_defs.sv
// ipg_defs -- block-type and sync-header constants shared by the TX
// scheduler and the RX extractor, plus the TX gap-tracking state type.
//   SYNC_*        : 2-bit sync headers
//   BT_*          : control block-type bytes (in_data[7:0] of a control block)
//   is_start()    : block type opens a frame
//   is_term()     : block type closes a frame
package ipg_defs;

  localparam logic [1:0] SYNC_DATA = 2'b10;
  localparam logic [1:0] SYNC_CTRL = 2'b01;

  localparam logic [7:0] BT_IDLE     = 8'h1e;
  localparam logic [7:0] BT_REQ      = 8'h1a;
  localparam logic [7:0] BT_RESP     = 8'h1f;
  localparam logic [7:0] BT_START_L0 = 8'h33;
  localparam logic [7:0] BT_START_L4 = 8'h78;

  typedef enum logic [1:0] {
    ST_FRAME = 2'd0,
    ST_GUARD = 2'd1,
    ST_GAP   = 2'd2
  } tx_state_e;

  function automatic logic is_start(input logic [7:0] bt);
    return (bt == BT_START_L0) || (bt == BT_START_L4);
  endfunction

  function automatic logic is_term(input logic [7:0] bt);
    return bt inside {8'h87, 8'h99, 8'haa, 8'hb4, 8'hcc, 8'hd2, 8'he1, 8'hff};
  endfunction

endpackage

// File: rtl/ipg_slot_arb.sv
// ipg_slot_arb -- picks REQ or RESP for a free idle slot.
//   clk, rst_n               : clock, async active-low reset
//   enable                   : insertion enable; low freezes the streak
//   slot_open                : current block is an eligible idle inside the gap
//   req_valid, resp_valid    : pending payloads
//   req_ready, resp_ready    : combinational one-hot grant for this cycle
// RESP is favoured, but after RESP_BURST_MAX back-to-back RESP grants with a
// REQ waiting, the next slot goes to REQ so it cannot be starved.
module ipg_slot_arb
  import ipg_defs::*;
#(
  parameter int RESP_BURST_MAX = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic slot_open,
  input  logic req_valid,
  input  logic resp_valid,
  output logic req_ready,
  output logic resp_ready
);

  localparam int SW = (RESP_BURST_MAX < 1) ? 1 : $clog2(RESP_BURST_MAX + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(RESP_BURST_MAX);

  logic [SW-1:0] streak_q;
  logic          opp;
  logic          resp_win;

  always_comb begin
    opp        = slot_open && enable;
    resp_win   = resp_valid && (!req_valid || (streak_q != STREAK_MAX));
    req_ready  = opp && req_valid && !resp_win;
    resp_ready = opp && resp_win;
  end

  // The streak only measures how long a waiting REQ has been passed over,
  // so it resets whenever no REQ is waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      streak_q <= '0;
    end else if (enable) begin
      if (req_ready || !req_valid) begin
        streak_q <= '0;
      end else if (resp_ready && (streak_q != STREAK_MAX)) begin
        streak_q <= streak_q + SW'(1);
      end
    end
  end

endmodule

// File: rtl/ipg_tx_sched.sv
// ipg_tx_sched -- replaces eligible idle blocks in the TX inter-packet gap
// with REQ / RESP payload blocks; everything else passes with 1-cycle latency.
//   clk, rst_n                      : clock, async active-low reset
//   enable                          : insertion enable
//   in_hdr, in_data                 : encoded block from the encoder
//   req_valid/req_ready/req_data    : REQ payload handshake
//   resp_valid/resp_ready/resp_data : RESP payload handshake
//   out_hdr, out_data               : block to the PHY (registered)
//   req_cnt, resp_cnt               : inserted block counters (wrapping)
//
// state    | meaning
// ST_FRAME | inside a frame (or after a bad header); no insertion
// ST_GUARD | after a terminate; guard_cnt idles still pass untouched
// ST_GAP   | gap open; eligible idles may be replaced
module ipg_tx_sched
  import ipg_defs::*;
#(
  parameter int GUARD_BLOCKS   = 1,
  parameter int RESP_BURST_MAX = 4,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [1:0]       in_hdr,
  input  logic [63:0]      in_data,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [55:0]      req_data,
  input  logic             resp_valid,
  output logic             resp_ready,
  input  logic [55:0]      resp_data,
  output logic [1:0]       out_hdr,
  output logic [63:0]      out_data,
  output logic [CNT_W-1:0] req_cnt,
  output logic [CNT_W-1:0] resp_cnt
);

  localparam int GW = (GUARD_BLOCKS < 1) ? 1 : $clog2(GUARD_BLOCKS + 1);
  localparam logic [GW-1:0] GUARD_INIT = GW'(GUARD_BLOCKS);

  tx_state_e     state_q, state_d;
  logic [GW-1:0] guard_q, guard_d;
  logic [7:0]    blk_type;
  logic          elig_idle;
  logic          slot_open;

  assign blk_type  = in_data[7:0];
  assign elig_idle = (in_hdr == SYNC_CTRL) && (in_data == {56'h0, BT_IDLE});
  assign slot_open = (state_q == ST_GAP) && elig_idle;

  // The FSM tracks the stream even with enable low, so re-enabling mid-gap
  // never inserts into a frame.
  always_comb begin
    state_d = state_q;
    guard_d = guard_q;
    if (in_hdr != SYNC_CTRL) begin
      state_d = ST_FRAME;
    end else if (is_start(blk_type)) begin
      state_d = ST_FRAME;
    end else if (is_term(blk_type)) begin
      guard_d = GUARD_INIT;
      state_d = (GUARD_BLOCKS == 0) ? ST_GAP : ST_GUARD;
    end else if (elig_idle && (state_q == ST_GUARD)) begin
      // The idle that exhausts the guard still passes; the gap opens after it.
      if (guard_q <= GW'(1)) begin
        guard_d = '0;
        state_d = ST_GAP;
      end else begin
        guard_d = guard_q - GW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_GUARD;
      guard_q <= GUARD_INIT;
    end else begin
      state_q <= state_d;
      guard_q <= guard_d;
    end
  end

  ipg_slot_arb #(
    .RESP_BURST_MAX(RESP_BURST_MAX)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .slot_open (slot_open),
    .req_valid (req_valid),
    .resp_valid(resp_valid),
    .req_ready (req_ready),
    .resp_ready(resp_ready)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_hdr  <= SYNC_CTRL;
      out_data <= {56'h0, BT_IDLE};
      req_cnt  <= '0;
      resp_cnt <= '0;
    end else begin
      if (req_ready) begin
        out_hdr  <= SYNC_CTRL;
        out_data <= {req_data, BT_REQ};
        req_cnt  <= req_cnt + CNT_W'(1);
      end else if (resp_ready) begin
        out_hdr  <= SYNC_CTRL;
        out_data <= {resp_data, BT_RESP};
        resp_cnt <= resp_cnt + CNT_W'(1);
      end else begin
        out_hdr  <= in_hdr;
        out_data <= in_data;
      end
    end
  end

endmodule

// File: doc/ipg_tx_sched.md
IPG_TX_SCHED -- requirements
Module: ipg_tx_sched

Interface
REQ-001 Parameter GUARD_BLOCKS, default 1: idle blocks after a terminate block that pass untouched before insertion is allowed.
REQ-002 Parameter RESP_BURST_MAX, default 4: maximum consecutive RESP grants while a REQ is pending.
REQ-003 Parameter CNT_W, default 32: width of the statistics counters.
REQ-004 Port clk, input, 1: single clock; the block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 Port rst_n, input, 1: asynchronous active-low reset.
REQ-006 Port enable, input, 1: insertion enable; when low, the block acts as a pure 1-cycle pipeline.
REQ-007 Port in_hdr, input, 2: encoded TX sync header from the encoder.
REQ-008 Port in_data, input, 64: encoded TX block from the encoder.
REQ-009 Port req_valid / req_ready, input / output, 1 / 1: REQ payload handshake.
REQ-010 Port req_data, input, 56: REQ payload.
REQ-011 Port resp_valid / resp_ready, input / output, 1 / 1: RESP payload handshake.
REQ-012 Port resp_data, input, 56: RESP payload.
REQ-013 Port out_hdr / out_data, output, 2 / 64: encoded TX block sent to the PHY.
REQ-014 Port req_cnt / resp_cnt, output, CNT_W / CNT_W: number of inserted REQ / RESP blocks.

Function
REQ-015 out_hdr/out_data SHALL equal the cycle-N input or the substituted block at cycle N+1; latency is exactly 1 cycle, and no block is ever dropped or added.
REQ-016 Eligible idle: in_hdr==2'b01 AND in_data[7:0]==8'h1e AND in_data[63:8]==0.
REQ-017 FSM states are FRAME, GUARD and GAP, with reset state GUARD and guard_cnt=GUARD_BLOCKS.
REQ-018 FSM input events: in_hdr==2'b10, or a control block of type 8'h33/8'h78 -> FRAME. A terminate block of type 8'h87/99/aa/b4/cc/d2/e1/ff -> GUARD, guard_cnt=GUARD_BLOCKS.
REQ-019 GUARD: each eligible idle decrements guard_cnt; the block that brings guard_cnt to 0 is passed, and the FSM moves to GAP afterwards; GUARD_BLOCKS=0 -> GAP directly on the terminate.
REQ-020 Invalid header (2'b00/2'b11) SHALL pass unchanged and force FRAME.
REQ-021 Other control blocks (ordered sets, non-zero idle, 8'h1a/8'h1f already present) SHALL pass unchanged with no state change.
REQ-022 Grant opportunity: state==GAP AND eligible idle AND enable AND (req_valid OR resp_valid).
REQ-023 Arbitration with both requests valid: RESP wins unless resp_streak==RESP_BURST_MAX, in which case REQ wins.
REQ-024 Arbitration with a single request valid: that requester wins.
REQ-025 resp_streak SHALL increment (saturating) on a RESP grant and clear on a REQ grant or when req_valid is low.
REQ-026 req_ready/resp_ready SHALL be combinational, asserted only in the cycle of their own grant, mutually exclusive, and never asserted outside a grant opportunity.
REQ-027 A substituted block SHALL be out_hdr=2'b01, out_data[7:0]=8'h1a (REQ) or 8'h1f (RESP), and out_data[63:8]=payload.
REQ-028 req_cnt/resp_cnt SHALL increment by 1 per grant and wrap modulo 2^CNT_W.
REQ-029 enable low SHALL still let the FSM track, while no grants occur and resp_streak holds.
REQ-030 Payload data is sampled only on the ready cycle; valid deassertion without ready SHALL be legal.

Reset
REQ-031 rst_n low SHALL asynchronously force out_hdr=2'b01, out_data=64'h1e, req_cnt=0, resp_cnt=0, resp_streak=0, state GUARD, and guard_cnt=GUARD_BLOCKS.
REQ-032 While rst_n is low, req_ready and resp_ready SHALL be 0; a reset in mid-gap SHALL abandon any pending grant, with no partial substitution.

Structure
REQ-033 Block-type constants (8'h1a REQ, 8'h1f RESP, 8'h1e CTRL, start and terminate codes) and sync codes SHALL live in the shared ipg_defs package/include, which is also used by the RX side.
REQ-034 Arbitration plus resp_streak SHALL be one sub-module, ipg_slot_arb; the FSM, pipeline register and counters SHALL live in the top module.

Verification
REQ-035 Test: TERM_0 followed by 4 eligible idles, resp_valid=1, resp_data=56'hA5..., GUARD_BLOCKS=1 -> idle 1 passes as 64'h1e, idles 2-4 are output as 8'h1f blocks, resp_cnt=3, and every output lags its input by 1 cycle.
REQ-036 Test: both requests always valid over 12 gap idles, RESP_BURST_MAX=4 -> grant pattern RRRRQRRRRQRR, req_cnt=2, resp_cnt=10.
REQ-037 Test: a start block 8'h78 arrives in GAP with req_valid=1 -> no ready, the start and data blocks pass bit-exact, and no insertion occurs until TERM+guard.
REQ-038 Test: enable=0 for the full gap -> output equals input delayed by 1 cycle, ready stays 0, and the counters do not change.
REQ-039 Test: rst_n asserted mid-gap during a grant cycle -> outputs immediately show idle 64'h1e with counters at 0, and the first grant after release occurs only after GUARD_BLOCKS idles.
REQ-040 Test: resp_cnt preloaded near all-ones (CNT_W=4), then 3 RESP grants -> counter wraps 14, 15, 0, 1.
